prog_loader: RTL and testbench

- Write-side initiator for the byte-wide instruction/data memories of the simple CPU.
- Accepts a byte stream over a valid/ready handshake and drives the memory write port (addr/we/din) to place a program image at a base address.
- Holds the CPU off the memories while loading.
- Instructions are 16-bit and stored big-endian across two consecutive bytes. The loader writes bytes in stream order, so the high byte must be sent first.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 36 +++
 rtl/prog_loader_wr_stage.sv | 63 ++++++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: loader state encoding, the
// default memory geometry of the CPU instruction/data memories, and the
// running-checksum helper.
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    CKSUM = 2'd3
  } state_t;

  // Modulo-256 accumulation of one stream byte into the running checksum.
  function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// slave  : the loader (consumes the stream, drives the memory write port).
// master : the stream source / memory side (testbench or CPU wrapper).
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_we,
    output mem_din
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_we,
    input  mem_din
  );

endinterface

// File: rtl/prog_loader_wr_stage.sv
// Registered memory write stage of the program loader. Holds the write
// pointer, turns each accepted byte into a one-cycle write at the pointer
// on the following cycle, and advances the pointer modulo the memory depth.
module prog_loader_wr_stage
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_din_o
);

  logic [ADDR_W-1:0] ptr_q,  ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q,   we_d;
  logic [DATA_W-1:0] din_q,  din_d;

  // Next-state: load pointer on start, emit a write and bump pointer on accept.
  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 1'b0;
    if (load_i) begin
      ptr_d = base_i;
    end else if (accept_i) begin
      addr_d = ptr_q;
      din_d  = data_i;
      we_d   = 1'b1;
      ptr_d  = ptr_q + ADDR_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Write-stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      din_q  <= din_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_we_o   = we_q;
  assign mem_din_o  = din_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a byte stream and writes it into the CPU memory
// starting at base_addr, holding the CPU off the memory while loading.
// Optional trailing checksum byte enabled by macro PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  prog_loader_if.slave      bus,
  output logic              busy_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] CNT_ZERO = '0;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q,   cnt_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            in_ready_s;
  logic            load_ptr_s;
  logic            wr_accept_s;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]      sum_q,   sum_d;
  logic            err_q,   err_d;
`endif

  // Next-state, counter, checksum and handshake decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_s  = 1'b0;
    load_ptr_s  = 1'b0;
    wr_accept_s = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef PROG_LOADER_CKSUM_EN
          err_d = 1'b0;
          sum_d = 8'h00;
`endif
          if (length_i == CNT_ZERO) begin
            // Empty image: complete immediately without entering LOAD.
            done_d = 1'b1;
          end else begin
            load_ptr_s = 1'b1;
            cnt_d      = length_i;
            busy_d     = 1'b1;
            state_d    = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          wr_accept_s = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d       = cksum_add(sum_q, bus.in_data[7:0]);
`endif
          if (cnt_q == CNT_ONE) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = CKSUM;
`else
            state_d = FLUSH;
`endif
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: begin
        // Trailing checksum byte is consumed but never written to memory.
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          if (cksum_add(sum_q, bus.in_data[7:0]) != 8'h00) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d = FLUSH;
        end else begin
          state_d = CKSUM;
        end
      end
`endif
      FLUSH: begin
        // Last write is on the port this cycle; finish on the next.
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous active-low reset (aborts any load).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  prog_loader_wr_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_ptr_s),
    .base_i     (base_addr_i),
    .accept_i   (wr_accept_s),
    .data_i     (bus.in_data),
    .mem_addr_o (bus.mem_addr),
    .mem_we_o   (bus.mem_we),
    .mem_din_o  (bus.mem_din)
  );

  assign bus.in_ready = in_ready_s;
  assign busy_o       = busy_q;
  assign cpu_hold_o   = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader. Outputs are sampled 1ns
// after the rising edge; a small memory model captures every write.
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base;
  logic [8:0] len;
  logic       busy, cpu_hold, done, err;

  int checks;
  int errors;
  int wr_count;
  logic [7:0] tb_mem [256];

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base),
    .length_i    (len),
    .bus         (bus.slave),
    .busy_o      (busy),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a write on the port lands on the next rising edge.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr] <= bus.mem_din;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Supplies the correct trailing checksum byte when that feature is built in.
  task automatic cksum_tail(input logic [7:0] sum);
`ifdef PROG_LOADER_CKSUM_EN
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00 - sum;
    tick();
    bus.in_valid = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base = 8'h00; len = 9'd0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", bus.mem_din); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
    checks++; if ({busy, cpu_hold, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, cpu_hold, done, err}); end
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    start = 1'b1; base = 8'h10; len = 9'd4;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold: got %b want 1", cpu_hold); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_pre: got %b want 0", bus.mem_we); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = b[i];
      tick();
      checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL basic_we[%0d]: got %b want 1", i, bus.mem_we); end
      checks++; if (bus.mem_addr !== 8'h10 + 8'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, bus.mem_addr, 8'h10 + 8'(i)); end
      checks++; if (bus.mem_din !== b[i]) begin errors++; $display("FAIL basic_din[%0d]: got %h want %h", i, bus.mem_din, b[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d]: got %b want 0", i, done); end
    end
    bus.in_valid = 1'b0;
    cksum_tail(8'h14);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_flush_ready: got %b want 0", bus.in_ready); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_flush: got busy=%b done=%b want 1 0", busy, done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b%b want 00", busy, cpu_hold); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_end: got %b want 0", bus.mem_we); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if ({tb_mem[8'h10], tb_mem[8'h11]} !== 16'h1234) begin errors++; $display("FAIL basic_instr0: got %h want 1234", {tb_mem[8'h10], tb_mem[8'h11]}); end
    checks++; if ({tb_mem[8'h12], tb_mem[8'h13]} !== 16'h5678) begin errors++; $display("FAIL basic_instr1: got %h want 5678", {tb_mem[8'h12], tb_mem[8'h13]}); end
  endtask

  task automatic test_wrap();
    logic [7:0] b [4];
    logic [7:0] a [4];
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    start = 1'b1; base = 8'hFE; len = 9'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = b[i];
      tick();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== a[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got we=%b addr=%h want 1 %h", i, bus.mem_we, bus.mem_addr, a[i]); end
    end
    bus.in_valid = 1'b0;
    cksum_tail(8'h8A);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
    checks++; if ({tb_mem[8'hFF], tb_mem[8'h00]} !== 16'hA2A3) begin errors++; $display("FAIL wrap_mem: got %h want a2a3", {tb_mem[8'hFF], tb_mem[8'h00]}); end
  endtask

  task automatic test_gaps();
    int wr0;
    wr0 = wr_count;
    start = 1'b1; base = 8'h40; len = 9'd2;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h40 || bus.mem_din !== 8'hAA) begin errors++; $display("FAIL gaps_w0: got %b %h %h want 1 40 aa", bus.mem_we, bus.mem_addr, bus.mem_din); end
    bus.in_valid = 1'b0; bus.in_data = 8'h55;
    start = 1'b1; base = 8'h80; len = 9'd5;
    tick();
    start = 1'b0;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h40 || bus.mem_din !== 8'hAA) begin errors++; $display("FAIL gaps_hold1: got %b %h %h want 0 40 aa", bus.mem_we, bus.mem_addr, bus.mem_din); end
    tick();
    checks++; if (bus.mem_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gaps_hold2: got we=%b busy=%b want 0 1", bus.mem_we, busy); end
    bus.in_valid = 1'b1; bus.in_data = 8'hBB;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h41 || bus.mem_din !== 8'hBB) begin errors++; $display("FAIL gaps_w1: got %b %h %h want 1 41 bb", bus.mem_we, bus.mem_addr, bus.mem_din); end
    bus.in_valid = 1'b0;
    cksum_tail(8'h65);
    bus.in_valid = 1'b1; bus.in_data = 8'hCC;
    tick();
    checks++; if (done !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL gaps_flush_valid: got done=%b we=%b want 1 0", done, bus.mem_we); end
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gaps_idle_valid: got rdy=%b we=%b busy=%b want 0 0 0", bus.in_ready, bus.mem_we, busy); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (wr_count - wr0 !== 2) begin errors++; $display("FAIL gaps_count: got %0d want 2", wr_count - wr0); end
  endtask

  task automatic test_zero_len();
    int wr0;
    wr0 = wr_count;
    start = 1'b1; base = 8'h20; len = 9'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b we=%b rdy=%b want 0 0 0", busy, bus.mem_we, bus.in_ready); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL zero_writes: got %0d want %0d", wr_count, wr0); end
  endtask

  task automatic test_reset_midload();
    start = 1'b1; base = 8'h60; len = 9'd5;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    tick();
    bus.in_data = 8'h22;
    tick();
    bus.in_data = 8'h33;
    rst_n = 1'b0;
    tick();
    checks++; if (bus.mem_addr !== 8'h00 || bus.mem_we !== 1'b0 || bus.mem_din !== 8'h00) begin errors++; $display("FAIL rst_mid_port: got %h %b %h want 00 0 00", bus.mem_addr, bus.mem_we, bus.mem_din); end
    checks++; if ({bus.in_ready, busy, cpu_hold, done, err} !== 5'b00000) begin errors++; $display("FAIL rst_mid_flags: got %b want 00000", {bus.in_ready, busy, cpu_hold, done, err}); end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (done !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet[%0d]: got done=%b we=%b want 0 0", i, done, bus.mem_we); end
    end
    checks++; if ({tb_mem[8'h60], tb_mem[8'h61]} !== 16'h1122) begin errors++; $display("FAIL rst_mid_kept: got %h want 1122", {tb_mem[8'h60], tb_mem[8'h61]}); end
    start = 1'b1; base = 8'h70; len = 9'd1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h70 || bus.mem_din !== 8'h5A) begin errors++; $display("FAIL rst_reload_w: got %b %h %h want 1 70 5a", bus.mem_we, bus.mem_addr, bus.mem_din); end
    cksum_tail(8'h5A);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_reload_done: got %b want 1", done); end
  endtask

`ifdef PROG_LOADER_CKSUM_EN
  task automatic test_cksum();
    start = 1'b1; base = 8'h90; len = 9'd2;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    tick();
    bus.in_data = 8'h02;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.mem_addr !== 8'h91) begin errors++; $display("FAIL ck_state: got rdy=%b addr=%h want 1 91", bus.in_ready, bus.mem_addr); end
    bus.in_data = 8'hFD;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ck_good: got we=%b err=%b want 0 0", bus.mem_we, err); end
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ck_good_done: got done=%b err=%b want 1 0", done, err); end
    start = 1'b1; base = 8'hA0; len = 9'd2;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    tick();
    bus.in_data = 8'h02;
    tick();
    bus.in_data = 8'hFE;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (err !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ck_bad: got err=%b we=%b want 1 0", err, bus.mem_we); end
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL ck_bad_done: got done=%b err=%b want 1 1", done, err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ck_sticky: got %b want 1", err); end
    checks++; if ({tb_mem[8'hA0], tb_mem[8'hA1]} !== 16'h0102) begin errors++; $display("FAIL ck_payload: got %h want 0102", {tb_mem[8'hA0], tb_mem[8'hA1]}); end
    start = 1'b1; base = 8'h00; len = 9'd0;
    tick();
    start = 1'b0;
    checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ck_clear: got err=%b done=%b want 0 1", err, done); end
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_zero_len();
    test_reset_midload();
`ifdef PROG_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
